// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator display path
package calc_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX_WIDTH = 9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ = 4'd3;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake and digit bus of the BCD converter
interface bin_to_bcd_seq_if #(parameter int WIDTH = 8);
    import calc_pkg::*;
    logic start;
    logic [WIDTH-1:0] bin;
    logic busy;
    logic done;
    logic [BCD_DIGIT_W-1:0] ones;
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] hundreds;
    modport master (output start, bin, input busy, done, ones, tens, hundreds);
    modport slave (input start, bin, output busy, done, ones, tens, hundreds);
endinterface

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble correction cell, adds 3 to a digit of 5 or more
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = (d >= BCD_THRESH) ? d + BCD_ADJ : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: serial shift-and-add-3 binary to three-digit BCD converter
module bin_to_bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 3 * BCD_DIGIT_W + WIDTH;

    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] sr;
    logic [BCD_DIGIT_W-1:0] h, t, o, ha, ta, oa;
    logic [SW-1:0] sh;

    bcd_add3 u_ones (.d(o), .q(oa));
    bcd_add3 u_tens (.d(t), .q(ta));
    bcd_add3 u_hundreds (.d(h), .q(ha));

    // corrected scratch digits and operand shifted as one word
    assign sh = {ha, ta, oa, sr} << 1;

    // conversion FSM; busy covers every shift cycle and drops with the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            {h, t, o} <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            {bus.hundreds, bus.tens, bus.ones} <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    sr <= bus.bin;
                    {h, t, o} <= '0;
                    cnt <= CW'(WIDTH);
                    bus.busy <= 1'b1;
                    state <= SHIFT;
                end
            end else begin
                {h, t, o, sr} <= sh;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    {bus.hundreds, bus.tens, bus.ones} <= sh[SW-1 -: 3*BCD_DIGIT_W];
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for the serial BCD converter (WIDTH 8 and 9)
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.WIDTH(8)) b8 ();
    bin_to_bcd_seq_if #(.WIDTH(9)) b9 ();

    bin_to_bcd_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    bin_to_bcd_seq #(.WIDTH(9)) dut9 (.clk(clk), .rst_n(rst_n), .bus(b9.slave));

    int n_chk = 0;
    int n_fail = 0;
    int q8[$];
    int q9[$];
    int held8 = 0;
    int held9 = 0;
    int acc8 = 0;
    int dones8 = 0;
    int dones9 = 0;

    function automatic int bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // record every accepted request with its expected digits
    always @(posedge clk) begin
        if (rst_n && b8.start && !b8.busy) begin
            q8.push_back(bcd(int'(b8.bin)));
            acc8++;
        end
        if (rst_n && b9.start && !b9.busy) q9.push_back(bcd(int'(b9.bin)));
    end

    // compare digits on done, otherwise require the last result to be held
    always @(negedge clk) begin
        if (rst_n) begin
            if (b8.done) begin
                dones8++;
                if (q8.size() == 0) chk("done8_unexpected", 1, 0);
                else begin
                    held8 = q8.pop_front();
                    chk("digits8", int'({b8.hundreds, b8.tens, b8.ones}), held8);
                end
            end else chk("hold8", int'({b8.hundreds, b8.tens, b8.ones}), held8);
            if (b9.done) begin
                dones9++;
                if (q9.size() == 0) chk("done9_unexpected", 1, 0);
                else begin
                    held9 = q9.pop_front();
                    chk("digits9", int'({b9.hundreds, b9.tens, b9.ones}), held9);
                end
            end else chk("hold9", int'({b9.hundreds, b9.tens, b9.ones}), held9);
        end
    end

    task automatic conv8(input int v);
        int lat;
        int ok;
        lat = 0;
        ok = 1;
        @(negedge clk);
        b8.bin = v[7:0];
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        while (!b8.done && lat < 20) begin
            if (!b8.busy) ok = 0;
            @(negedge clk);
            lat++;
        end
        chk("latency8", lat, 8);
        chk("busy8_during", ok, 1);
        chk("busy8_at_done", int'(b8.busy), 0);
        @(negedge clk);
        chk("done8_pulse", int'(b8.done), 0);
    endtask

    task automatic conv9(input int v);
        int lat;
        lat = 0;
        @(negedge clk);
        b9.bin = v[8:0];
        b9.start = 1'b1;
        @(negedge clk);
        b9.start = 1'b0;
        while (!b9.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency9", lat, 9);
        chk("busy9_at_done", int'(b9.busy), 0);
        @(negedge clk);
        chk("done9_pulse", int'(b9.done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        int target;
        int g;
        b8.start = 1'b0;
        b8.bin = '0;
        b9.start = 1'b0;
        b9.bin = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", int'(b8.busy), 0);
        chk("rst_done8", int'(b8.done), 0);
        chk("rst_digits8", int'({b8.hundreds, b8.tens, b8.ones}), 0);
        chk("rst_busy9", int'(b9.busy), 0);
        chk("rst_digits9", int'({b9.hundreds, b9.tens, b9.ones}), 0);
        rst_n = 1'b1;

        conv8(0);
        conv8(255);
        conv8(100);
        conv8(9);
        conv8(99);

        base = dones8;
        b8.start = 1'b1;
        for (int v = 0; v < 256; v++) begin
            b8.bin = v[7:0];
            target = acc8 + 1;
            g = 0;
            while (acc8 < target && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (g >= 40) chk("sweep_accept", 0, 1);
        end
        b8.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("sweep_dones", dones8 - base, 256);
        chk("sweep_drain", q8.size(), 0);

        base = dones8;
        @(negedge clk);
        b8.bin = 8'd123;
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        repeat (2) @(negedge clk);
        b8.bin = 8'd45;
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        repeat (15) @(negedge clk);
        chk("ignore_dones", dones8 - base, 1);
        chk("ignore_queue", q8.size(), 0);

        conv8(200);
        base = dones8;
        @(negedge clk);
        b8.bin = 8'd77;
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(b8.busy), 0);
        chk("abort_done", int'(b8.done), 0);
        chk("abort_digits", int'({b8.hundreds, b8.tens, b8.ones}), 0);
        held8 = 0;
        q8.delete();
        repeat (3) @(negedge clk);
        chk("abort_dones", dones8 - base, 0);
        rst_n = 1'b1;
        conv8(77);

        conv9(511);
        conv9(300);
        chk("dones9", dones9, 2);
        chk("final_q8", q8.size(), 0);
        chk("final_q9", q9.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
